// File: rtl/peridot_hostfifo.sv
// Host-side stream buffer: independent host-to-fabric (up) and fabric-to-host (down)
// show-ahead FIFOs, with a sticky overrun flag and optional RTS/CTS flow control.
module peridot_hostfifo #(
  parameter int unsigned UP_DEPTH_LOG2   = 6,
  parameter int unsigned DOWN_DEPTH_LOG2 = 6,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter string       FLOWCTRL_MODE   = "NONE",
  parameter int unsigned RTS_THRESHOLD   = 2**UP_DEPTH_LOG2 - 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       up_in_valid,
  input  logic [DATA_WIDTH-1:0]      up_in_data,
  output logic                       up_in_ready,
  output logic                       up_out_valid,
  output logic [DATA_WIDTH-1:0]      up_out_data,
  input  logic                       up_out_ready,
  input  logic                       down_in_valid,
  input  logic [DATA_WIDTH-1:0]      down_in_data,
  output logic                       down_in_ready,
  output logic                       down_out_valid,
  output logic [DATA_WIDTH-1:0]      down_out_data,
  input  logic                       down_out_ready,
  output logic                       coe_rts_n,
  input  logic                       coe_cts_n,
  output logic [UP_DEPTH_LOG2:0]     up_usedw,
  output logic [DOWN_DEPTH_LOG2:0]   down_usedw,
  output logic                       overflow,
  input  logic                       overflow_clear
);

  localparam int unsigned UP_DEPTH = 2**UP_DEPTH_LOG2;
  localparam int unsigned UP_CW    = UP_DEPTH_LOG2 + 1;
  localparam int unsigned DN_DEPTH = 2**DOWN_DEPTH_LOG2;
  localparam int unsigned DN_CW    = DOWN_DEPTH_LOG2 + 1;
  localparam bit          USE_FC   = (FLOWCTRL_MODE == "RTSCTS");

  // ---------------------------------------------------------------- up path
  logic [DATA_WIDTH-1:0]    up_mem_q [UP_DEPTH];
  logic [UP_DEPTH_LOG2-1:0] up_wr_ptr_q, up_wr_ptr_d;
  logic [UP_DEPTH_LOG2-1:0] up_rd_ptr_q, up_rd_ptr_d;
  logic [UP_CW-1:0]         up_count_q, up_count_d;
  logic                     up_full;
  logic                     up_empty;
  logic                     up_wr;
  logic                     up_rd;

  // ---------------------------------------------------------------- down path
  logic [DATA_WIDTH-1:0]      dn_mem_q [DN_DEPTH];
  logic [DOWN_DEPTH_LOG2-1:0] dn_wr_ptr_q, dn_wr_ptr_d;
  logic [DOWN_DEPTH_LOG2-1:0] dn_rd_ptr_q, dn_rd_ptr_d;
  logic [DN_CW-1:0]           dn_count_q, dn_count_d;
  logic                       dn_full;
  logic                       dn_empty;
  logic                       dn_wr;
  logic                       dn_rd;

  // ---------------------------------------------------------------- status / flow control
  logic overflow_q, overflow_d;
  logic rts_n_q, rts_n_d;
  logic cts_s1_q, cts_s1_d;
  logic cts_s2_q, cts_s2_d;
  logic host_can_accept;

  // Handshake qualification; a full FIFO refuses writes even when it is being read.
  always_comb begin
    up_full         = (up_count_q == UP_CW'(UP_DEPTH));
    up_empty        = (up_count_q == '0);
    dn_full         = (dn_count_q == DN_CW'(DN_DEPTH));
    dn_empty        = (dn_count_q == '0);
    host_can_accept = USE_FC ? ~cts_s2_q : 1'b1;
    up_wr           = up_in_valid & ~up_full;
    up_rd           = up_out_ready & ~up_empty;
    dn_wr           = down_in_valid & ~dn_full;
    dn_rd           = down_out_ready & ~dn_empty & host_can_accept;
  end

  // Up FIFO pointer and fill-count next state.
  always_comb begin
    up_wr_ptr_d = up_wr_ptr_q;
    up_rd_ptr_d = up_rd_ptr_q;
    up_count_d  = up_count_q;
    if (up_wr) begin
      up_wr_ptr_d = up_wr_ptr_q + UP_DEPTH_LOG2'(1);
    end
    if (up_rd) begin
      up_rd_ptr_d = up_rd_ptr_q + UP_DEPTH_LOG2'(1);
    end
    if (up_wr && !up_rd) begin
      up_count_d = up_count_q + UP_CW'(1);
    end else if (!up_wr && up_rd) begin
      up_count_d = up_count_q - UP_CW'(1);
    end
  end

  // Down FIFO pointer and fill-count next state.
  always_comb begin
    dn_wr_ptr_d = dn_wr_ptr_q;
    dn_rd_ptr_d = dn_rd_ptr_q;
    dn_count_d  = dn_count_q;
    if (dn_wr) begin
      dn_wr_ptr_d = dn_wr_ptr_q + DOWN_DEPTH_LOG2'(1);
    end
    if (dn_rd) begin
      dn_rd_ptr_d = dn_rd_ptr_q + DOWN_DEPTH_LOG2'(1);
    end
    if (dn_wr && !dn_rd) begin
      dn_count_d = dn_count_q + DN_CW'(1);
    end else if (!dn_wr && dn_rd) begin
      dn_count_d = dn_count_q - DN_CW'(1);
    end
  end

  // Sticky overrun (a coincident overrun beats the clear), RTS from last fill, CTS synchroniser.
  always_comb begin
    overflow_d = overflow_q;
    rts_n_d    = 1'b0;
    cts_s1_d   = coe_cts_n;
    cts_s2_d   = cts_s1_q;
    if (up_in_valid && up_full) begin
      overflow_d = 1'b1;
    end else if (overflow_clear) begin
      overflow_d = 1'b0;
    end
    if (USE_FC) begin
      rts_n_d = (32'(up_count_q) >= RTS_THRESHOLD);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      up_wr_ptr_q <= '0;
      up_rd_ptr_q <= '0;
      up_count_q  <= '0;
      dn_wr_ptr_q <= '0;
      dn_rd_ptr_q <= '0;
      dn_count_q  <= '0;
      overflow_q  <= 1'b0;
      rts_n_q     <= 1'b1;
      cts_s1_q    <= 1'b1;
      cts_s2_q    <= 1'b1;
    end else begin
      up_wr_ptr_q <= up_wr_ptr_d;
      up_rd_ptr_q <= up_rd_ptr_d;
      up_count_q  <= up_count_d;
      dn_wr_ptr_q <= dn_wr_ptr_d;
      dn_rd_ptr_q <= dn_rd_ptr_d;
      dn_count_q  <= dn_count_d;
      overflow_q  <= overflow_d;
      rts_n_q     <= rts_n_d;
      cts_s1_q    <= cts_s1_d;
      cts_s2_q    <= cts_s2_d;
    end
  end

  // Storage arrays carry no reset; stale words are masked by the valid gating below.
  always_ff @(posedge clk) begin
    if (up_wr) begin
      up_mem_q[up_wr_ptr_q] <= up_in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (dn_wr) begin
      dn_mem_q[dn_wr_ptr_q] <= down_in_data;
    end
  end

  always_comb begin
    up_in_ready    = ~up_full;
    up_out_valid   = ~up_empty;
    up_out_data    = up_out_valid ? up_mem_q[up_rd_ptr_q] : '0;
    up_usedw       = up_count_q;
    down_in_ready  = ~dn_full;
    down_out_valid = ~dn_empty & host_can_accept;
    down_out_data  = down_out_valid ? dn_mem_q[dn_rd_ptr_q] : '0;
    down_usedw     = dn_count_q;
    overflow       = overflow_q;
    coe_rts_n      = rts_n_q;
  end

endmodule

// File: tb/tb_peridot_hostfifo.sv
// Bench for peridot_hostfifo: queue-based reference model checked every cycle,
// a vector table for the up-path fill/overrun/drain, and directed corner sequences.
module tb_peridot_hostfifo;

  localparam int unsigned DL    = 2;
  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned THR   = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         up_in_valid, up_in_ready, up_out_valid, up_out_ready;
  logic [W-1:0] up_in_data, up_out_data;
  logic         down_in_valid, down_in_ready, down_out_valid, down_out_ready;
  logic [W-1:0] down_in_data, down_out_data;
  logic         coe_rts_n, coe_cts_n;
  logic [DL:0]  up_usedw, down_usedw;
  logic         overflow, overflow_clear;

  always #5 clk = ~clk;

  peridot_hostfifo #(
    .UP_DEPTH_LOG2  (DL),
    .DOWN_DEPTH_LOG2(DL),
    .DATA_WIDTH     (W),
    .FLOWCTRL_MODE  ("RTSCTS"),
    .RTS_THRESHOLD  (THR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .up_in_valid   (up_in_valid),
    .up_in_data    (up_in_data),
    .up_in_ready   (up_in_ready),
    .up_out_valid  (up_out_valid),
    .up_out_data   (up_out_data),
    .up_out_ready  (up_out_ready),
    .down_in_valid (down_in_valid),
    .down_in_data  (down_in_data),
    .down_in_ready (down_in_ready),
    .down_out_valid(down_out_valid),
    .down_out_data (down_out_data),
    .down_out_ready(down_out_ready),
    .coe_rts_n     (coe_rts_n),
    .coe_cts_n     (coe_cts_n),
    .up_usedw      (up_usedw),
    .down_usedw    (down_usedw),
    .overflow      (overflow),
    .overflow_clear(overflow_clear)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] m_up[$];
  logic [W-1:0] m_dn[$];
  bit           m_ovf  = 1'b0;
  bit           m_rts  = 1'b1;
  bit           m_cts1 = 1'b1;
  bit           m_cts2 = 1'b1;
  bit           cap_en = 1'b0;
  logic [W-1:0] got_dn[$];

  typedef struct {
    logic         uv;
    logic [W-1:0] ud;
    logic         ur;
    logic         clr;
    int           e_used;
    logic         e_vld;
    logic [W-1:0] e_data;
    logic         e_rdy;
    logic         e_rts;
    logic         e_ovf;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("m_up_usedw", 32'(up_usedw), m_up.size());
    check("m_up_out_valid", 32'(up_out_valid), 32'(m_up.size() > 0));
    if (m_up.size() > 0) check("m_up_out_data", 32'(up_out_data), 32'(m_up[0]));
    check("m_up_in_ready", 32'(up_in_ready), 32'(m_up.size() < DEPTH));
    check("m_down_usedw", 32'(down_usedw), m_dn.size());
    check("m_down_out_valid", 32'(down_out_valid), 32'(m_dn.size() > 0 && !m_cts2));
    if (m_dn.size() > 0 && !m_cts2) check("m_down_out_data", 32'(down_out_data), 32'(m_dn[0]));
    check("m_down_in_ready", 32'(down_in_ready), 32'(m_dn.size() < DEPTH));
    check("m_overflow", 32'(overflow), 32'(m_ovf));
    check("m_coe_rts_n", 32'(coe_rts_n), 32'(m_rts));
  endtask

  // One clock: snapshot inputs, advance the model by the spec rules, compare after the edge.
  task automatic step();
    bit           rst, uv, ur, dv, dr, clr, cts;
    logic [W-1:0] ud, dd;
    int           up_sz, dn_sz;
    bit           up_acc, up_pop, over, dn_acc, dn_pop;
    #1;
    rst = reset; uv = up_in_valid; ur = up_out_ready; ud = up_in_data;
    dv = down_in_valid; dr = down_out_ready; dd = down_in_data;
    clr = overflow_clear; cts = coe_cts_n;
    if (cap_en && down_out_valid === 1'b1 && dr) got_dn.push_back(down_out_data);
    up_sz  = m_up.size();
    dn_sz  = m_dn.size();
    up_acc = uv && (up_sz < DEPTH);
    over   = uv && (up_sz == DEPTH);
    up_pop = ur && (up_sz > 0);
    dn_acc = dv && (dn_sz < DEPTH);
    dn_pop = dr && (dn_sz > 0) && !m_cts2;
    @(posedge clk);
    #1;
    if (rst) begin
      m_up.delete();
      m_dn.delete();
      m_ovf  = 1'b0;
      m_rts  = 1'b1;
      m_cts1 = 1'b1;
      m_cts2 = 1'b1;
    end else begin
      if (up_pop) void'(m_up.pop_front());
      if (up_acc) m_up.push_back(ud);
      if (dn_pop) void'(m_dn.pop_front());
      if (dn_acc) m_dn.push_back(dd);
      m_rts = (up_sz >= THR);
      if (over) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_cts2 = m_cts1;
      m_cts1 = cts;
    end
    compare_model();
  endtask

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    // up-path fill, overrun, clear, overrun-vs-clear priority, drain, read of empty
    vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 3, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 4, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 8'h55, 1'b0, 1'b0, 4, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 8'h66, 1'b0, 1'b1, 4, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h44, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

    reset = 1'b1;
    up_in_valid = 1'b0; up_in_data = '0; up_out_ready = 1'b0;
    down_in_valid = 1'b0; down_in_data = '0; down_out_ready = 1'b0;
    coe_cts_n = 1'b0; overflow_clear = 1'b0;
    step();
    step();
    check("rst_up_usedw", 32'(up_usedw), 0);
    check("rst_down_usedw", 32'(down_usedw), 0);
    check("rst_up_in_ready", 32'(up_in_ready), 1);
    check("rst_down_in_ready", 32'(down_in_ready), 1);
    check("rst_up_out_valid", 32'(up_out_valid), 0);
    check("rst_down_out_valid", 32'(down_out_valid), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_rts_n", 32'(coe_rts_n), 1);
    reset = 1'b0;
    step();
    check("rts_after_release", 32'(coe_rts_n), 0);
    step();

    for (int i = 0; i < 13; i++) begin
      up_in_valid    = vecs[i].uv;
      up_in_data     = vecs[i].ud;
      up_out_ready   = vecs[i].ur;
      overflow_clear = vecs[i].clr;
      step();
      check($sformatf("vec%0d_usedw", i), 32'(up_usedw), vecs[i].e_used);
      check($sformatf("vec%0d_valid", i), 32'(up_out_valid), 32'(vecs[i].e_vld));
      if (vecs[i].e_vld) check($sformatf("vec%0d_data", i), 32'(up_out_data), 32'(vecs[i].e_data));
      check($sformatf("vec%0d_ready", i), 32'(up_in_ready), 32'(vecs[i].e_rdy));
      check($sformatf("vec%0d_rts_n", i), 32'(coe_rts_n), 32'(vecs[i].e_rts));
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
    end
    up_in_valid = 1'b0; up_out_ready = 1'b0; overflow_clear = 1'b0;
    step();

    // ten words through the down path, pointers wrap twice
    cap_en = 1'b1;
    got_dn.delete();
    down_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      down_in_valid = 1'b1;
      down_in_data  = W'(8'h30 + i);
      step();
    end
    down_in_valid = 1'b0;
    for (int i = 0; i < 8 && down_usedw != 0; i++) step();
    step();
    cap_en = 1'b0;
    check("stream_count", got_dn.size(), 10);
    for (int i = 0; i < 10 && i < got_dn.size(); i++)
      check($sformatf("stream_word%0d", i), 32'(got_dn[i]), 32'(8'h30 + i));
    check("stream_usedw_end", 32'(down_usedw), 0);

    // CTS hold-off and the two-flop release latency
    down_out_ready = 1'b0;
    coe_cts_n = 1'b1;
    step(); step(); step();
    down_in_valid = 1'b1; down_in_data = 8'hA5;
    step();
    down_in_valid = 1'b0;
    step(); step();
    check("cts_hold_valid", 32'(down_out_valid), 0);
    check("cts_hold_usedw", 32'(down_usedw), 1);
    coe_cts_n = 1'b0;
    step();
    check("cts_edge1_valid", 32'(down_out_valid), 0);
    step();
    check("cts_edge2_valid", 32'(down_out_valid), 1);
    check("cts_edge2_data", 32'(down_out_data), 32'h A5);
    coe_cts_n = 1'b1;
    step(); step();
    check("cts_drop_valid", 32'(down_out_valid), 0);
    check("cts_drop_keeps_word", 32'(down_usedw), 1);
    coe_cts_n = 1'b0;
    step(); step();
    down_out_ready = 1'b1;
    step();
    check("cts_drain_usedw", 32'(down_usedw), 0);
    down_out_ready = 1'b0;

    // simultaneous write and read at usedw=2
    up_in_valid = 1'b1; up_in_data = 8'hB0; step();
    up_in_data = 8'hB1; step();
    up_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      up_in_data = W'(8'hB2 + i);
      step();
      check($sformatf("wr_rd_usedw%0d", i), 32'(up_usedw), 2);
    end
    up_in_valid = 1'b0;
    step(); step();
    up_out_ready = 1'b0;

    // reset with three words in each FIFO
    for (int i = 0; i < 3; i++) begin
      up_in_valid = 1'b1; up_in_data = W'(8'hC0 + i);
      down_in_valid = 1'b1; down_in_data = W'(8'hD0 + i);
      step();
    end
    up_in_valid = 1'b0; down_in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("mid_rst_up_usedw", 32'(up_usedw), 0);
    check("mid_rst_down_usedw", 32'(down_usedw), 0);
    check("mid_rst_up_valid", 32'(up_out_valid), 0);
    check("mid_rst_down_valid", 32'(down_out_valid), 0);
    check("mid_rst_rts_n", 32'(coe_rts_n), 1);
    reset = 1'b0;
    step();
    check("mid_rst_release_rts_n", 32'(coe_rts_n), 0);

    // randomized traffic on both paths against the model
    for (int i = 0; i < 600; i++) begin
      up_in_valid    = ($urandom_range(0, 99) < 55);
      up_in_data     = W'($urandom);
      up_out_ready   = ($urandom_range(0, 99) < 50);
      down_in_valid  = ($urandom_range(0, 99) < 55);
      down_in_data   = W'($urandom);
      down_out_ready = ($urandom_range(0, 99) < 60);
      overflow_clear = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 99) < 10) coe_cts_n = ~coe_cts_n;
      reset          = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
